// File: rtl/fft_mem_sequencer_pkg.sv
// Shared constants, FSM state encoding and FP4 field helpers for the FFT memory sequencer.
package fft_mem_sequencer_pkg;

  localparam int unsigned N_POINTS   = 32;
  localparam int unsigned ADDR_W     = 5;
  localparam int unsigned NUM_STAGES = 5;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned STAGE_W    = 3;
  localparam int unsigned CNT_W      = ADDR_W - 1;
  localparam int unsigned FP4_W      = 4;

  typedef enum logic [2:0] {
    StIdle,
    StRdA,
    StRdB,
    StCap,
    StBf,
    StWrX,
    StWrY,
    StDone
  } state_e;

  // Word layout: [3:0] real part, [7:4] imaginary part.
  function automatic logic [FP4_W-1:0] fp4_re(input logic [DATA_W-1:0] w);
    return w[FP4_W-1:0];
  endfunction

  function automatic logic [FP4_W-1:0] fp4_im(input logic [DATA_W-1:0] w);
    return w[DATA_W-1:FP4_W];
  endfunction

endpackage

// File: rtl/fft_mem_sequencer_addr_gen.sv
// Radix-2 DIT butterfly addressing: (stage, butterfly index) -> operand addresses and twiddle.
module fft_mem_sequencer_addr_gen
  import fft_mem_sequencer_pkg::*;
(
  input  logic [STAGE_W-1:0] stage,
  input  logic [CNT_W-1:0]   bf_cnt,
  output logic [ADDR_W-1:0]  addr_a,
  output logic [ADDR_W-1:0]  addr_b,
  output logic [CNT_W-1:0]   tw_idx
);

  logic [ADDR_W-1:0] half;
  logic [CNT_W-1:0]  mask;
  logic [CNT_W-1:0]  lo;
  logic [CNT_W-1:0]  hi;

  always_comb begin
    half = ADDR_W'(1) << stage;
    mask = half[CNT_W-1:0] - CNT_W'(1);
    lo   = bf_cnt & mask;
    // hi is (k >> s) << s, so one extra left shift opens the gap for the b half.
    hi     = bf_cnt & ~mask;
    addr_a = {hi, 1'b0} | {1'b0, lo};
    addr_b = addr_a | half;
    tw_idx = lo << (STAGE_W'(NUM_STAGES - 1) - stage);
  end

endmodule

// File: rtl/fft_mem_sequencer.sv
// Radix-2 DIT stage sequencer: drives the ping-pong memory per butterfly and hands it to
// the host port while idle.
module fft_mem_sequencer
  import fft_mem_sequencer_pkg::*;
#(
  parameter int unsigned BF_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              start_bank,
  output logic              busy,
  output logic              done,
  output logic              result_bank,
  output logic              host_grant,
  input  logic              host_bank_sel,
  input  logic [ADDR_W-1:0] host_rd_addr,
  input  logic              host_wr_en,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [DATA_W-1:0] host_wr_data,
  output logic              mem_bank_sel,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              bf_valid,
  output logic [DATA_W-1:0] bf_a,
  output logic [DATA_W-1:0] bf_b,
  output logic [CNT_W-1:0]  bf_tw_idx,
  input  logic [DATA_W-1:0] bf_x,
  input  logic [DATA_W-1:0] bf_y
);

  localparam int unsigned LAT_W = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

  state_e              state_q, state_d;
  logic [STAGE_W-1:0]  stage_q, stage_d;
  logic [CNT_W-1:0]    bf_cnt_q, bf_cnt_d;
  logic                src_q, src_d;
  logic [DATA_W-1:0]   bf_a_q, bf_a_d;
  logic [DATA_W-1:0]   bf_b_q, bf_b_d;
  logic [DATA_W-1:0]   y_q, y_d;
  logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
  logic                result_bank_q, result_bank_d;

  logic [ADDR_W-1:0]   addr_a;
  logic [ADDR_W-1:0]   addr_b;
  logic [CNT_W-1:0]    tw_idx;

  fft_mem_sequencer_addr_gen u_addr_gen (
    .stage  (stage_q),
    .bf_cnt (bf_cnt_q),
    .addr_a (addr_a),
    .addr_b (addr_b),
    .tw_idx (tw_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      stage_q       <= '0;
      bf_cnt_q      <= '0;
      src_q         <= 1'b0;
      bf_a_q        <= '0;
      bf_b_q        <= '0;
      y_q           <= '0;
      lat_cnt_q     <= '0;
      result_bank_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      stage_q       <= stage_d;
      bf_cnt_q      <= bf_cnt_d;
      src_q         <= src_d;
      bf_a_q        <= bf_a_d;
      bf_b_q        <= bf_b_d;
      y_q           <= y_d;
      lat_cnt_q     <= lat_cnt_d;
      result_bank_q <= result_bank_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    stage_d       = stage_q;
    bf_cnt_d      = bf_cnt_q;
    src_d         = src_q;
    bf_a_d        = bf_a_q;
    bf_b_d        = bf_b_q;
    y_d           = y_q;
    lat_cnt_d     = lat_cnt_q;
    result_bank_d = result_bank_q;
    mem_bank_sel  = src_q;
    mem_rd_addr   = addr_a;
    mem_wr_en     = 1'b0;
    mem_wr_addr   = addr_a;
    mem_wr_data   = bf_x;
    bf_valid      = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;

    unique case (state_q)
      StIdle: begin
        mem_bank_sel = host_bank_sel;
        mem_rd_addr  = host_rd_addr;
        mem_wr_en    = host_wr_en;
        mem_wr_addr  = host_wr_addr;
        mem_wr_data  = host_wr_data;
        if (start) begin
          state_d  = StRdA;
          src_d    = start_bank;
          stage_d  = '0;
          bf_cnt_d = '0;
        end
      end
      StRdA: begin
        busy    = 1'b1;
        state_d = StRdB;
      end
      StRdB: begin
        busy        = 1'b1;
        mem_rd_addr = addr_b;
        bf_a_d      = mem_rd_data;
        state_d     = StCap;
      end
      StCap: begin
        busy      = 1'b1;
        bf_b_d    = mem_rd_data;
        lat_cnt_d = '0;
        state_d   = StBf;
      end
      StBf: begin
        busy     = 1'b1;
        bf_valid = (lat_cnt_q == '0);
        if (lat_cnt_q == LAT_W'(BF_LAT - 1)) begin
          state_d = StWrX;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      StWrX: begin
        busy         = 1'b1;
        mem_bank_sel = ~src_q;
        mem_wr_en    = 1'b1;
        mem_wr_addr  = addr_a;
        mem_wr_data  = bf_x;
        y_d          = bf_y;
        state_d      = StWrY;
      end
      StWrY: begin
        busy         = 1'b1;
        mem_bank_sel = ~src_q;
        mem_wr_en    = 1'b1;
        mem_wr_addr  = addr_b;
        mem_wr_data  = y_q;
        if (bf_cnt_q != CNT_W'(N_POINTS / 2 - 1)) begin
          bf_cnt_d = bf_cnt_q + CNT_W'(1);
          state_d  = StRdA;
        end else if (stage_q != STAGE_W'(NUM_STAGES - 1)) begin
          stage_d  = stage_q + STAGE_W'(1);
          bf_cnt_d = '0;
          src_d    = ~src_q;
          state_d  = StRdA;
        end else begin
          // Final stage wrote into ~src, which is where the result lives.
          result_bank_d = ~src_q;
          state_d       = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  assign host_grant  = ~busy;
  assign result_bank = result_bank_q;
  assign bf_a        = bf_a_q;
  assign bf_b        = bf_b_q;
  assign bf_tw_idx   = tw_idx;

endmodule
